// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and sync-polarity encodings,
// reusable by the renderer and sprite logic.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int POL_ACTIVE_LOW  = 0;
  localparam int POL_ACTIVE_HIGH = 1;

  function automatic int timing_total(input int active, input int fp, input int sync_w,
                                      input int bp);
    return active + fp + sync_w + bp;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX counter with advance enable, async reset and a registered
// terminal-count flag; o_next exposes the value being loaded this edge.
module wrap_counter #(
  parameter int MAX = 800,
  parameter int W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_next,
  output logic         o_wrap,
  output logic         o_tc
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] r_count;
  logic         r_tc;
  logic [W-1:0] w_next;
  logic         w_wrap;

  // Any count at or beyond LAST (including corrupted values) takes the wrap branch.
  always_comb begin
    w_wrap = (r_count >= LAST);
    w_next = r_count;
    if (i_en) begin
      w_next = w_wrap ? '0 : r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_next;
      r_tc    <= (w_next == LAST);
    end
  end

  assign o_count = r_count;
  assign o_next  = w_next;
  assign o_wrap  = w_wrap;
  assign o_tc    = r_tc;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters with pixel-enable stall, sync and
// blank decode registered from next-state counts, line/frame strobes, frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int HS_POL   = POL_ACTIVE_LOW,
  parameter int VS_POL   = POL_ACTIVE_LOW,
  parameter int CNT_W    = 16,
  parameter int FRM_W    = 8
) (
  input  logic             clk_25MHz,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_end,
  output logic             frame_end,
  output logic [FRM_W-1:0] frame_count
);

  localparam int     H_TOTAL  = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int     V_TOTAL  = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam longint CNT_SPAN = longint'(1) << CNT_W;

  if (H_TOTAL > CNT_SPAN || V_TOTAL > CNT_SPAN) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0)
  begin : g_bad_porch
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_ON    = 1'(HS_POL);
  localparam logic             VS_ON    = 1'(VS_POL);

  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_v_tc;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;
  logic             r_frame_end;
  logic [FRM_W-1:0] r_frame_count;

  wrap_counter #(.MAX(H_TOTAL), .W(CNT_W)) u_h_cnt (
    .clk     (clk_25MHz),
    .rst     (rst),
    .i_en    (en),
    .o_count (h_count),
    .o_next  (w_h_next),
    .o_wrap  (w_h_wrap),
    .o_tc    (line_end)
  );

  wrap_counter #(.MAX(V_TOTAL), .W(CNT_W)) u_v_cnt (
    .clk     (clk_25MHz),
    .rst     (rst),
    .i_en    (en & w_h_wrap),
    .o_count (v_count),
    .o_next  (w_v_next),
    .o_wrap  (w_v_wrap),
    .o_tc    (w_v_tc)
  );

  // When h lands on its last column, v cannot have moved this edge, so the
  // registered v terminal flag already describes the next line.
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      r_hsync       <= ~HS_ON;
      r_vsync       <= ~VS_ON;
      r_video_on    <= 1'b1;
      r_frame_end   <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_hsync     <= (w_h_next >= HS_START && w_h_next < HS_END) ? HS_ON : ~HS_ON;
      r_vsync     <= (w_v_next >= VS_START && w_v_next < VS_END) ? VS_ON : ~VS_ON;
      r_video_on  <= (w_h_next < H_ACT_C) && (w_v_next < V_ACT_C);
      r_frame_end <= (w_h_next == H_LAST) && w_v_tc;
      if (en && w_h_wrap && w_v_wrap) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign frame_end   = r_frame_end;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny active-high
// instance, both checked each cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, en_a = 1'b0;
  logic rst_b = 1'b1, en_b = 1'b0;

  logic [15:0] h_a, v_a, h_b, v_b;
  logic        hs_a, vs_a, von_a, le_a, fe_a;
  logic        hs_b, vs_b, von_b, le_b, fe_b;
  logic [7:0]  fc_a, fc_b;

  vga_timing_gen u_dut_a (
    .clk_25MHz (clk), .rst (rst_a), .en (en_a),
    .h_count (h_a), .v_count (v_a), .hsync (hs_a), .vsync (vs_a),
    .video_on (von_a), .line_end (le_a), .frame_end (fe_a), .frame_count (fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL (1), .VS_POL (1)
  ) u_dut_b (
    .clk_25MHz (clk), .rst (rst_b), .en (en_b),
    .h_count (h_b), .v_count (v_b), .hsync (hs_b), .vsync (vs_b),
    .video_on (von_b), .line_end (le_b), .frame_end (fe_b), .frame_count (fc_b)
  );

  int checks   = 0;
  int failures = 0;
  int n_a      = 0;  // enabled pixel steps since reset, instance A
  int n_b      = 0;
  bit saw_fc255 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Raster position follows directly from the number of enabled steps.
  task automatic check_dut(input string tag, input int n,
                           input int ha, input int hf, input int hsw, input int hb,
                           input int va, input int vf, input int vsw, input int vb,
                           input bit hpol, input bit vpol,
                           input logic [31:0] h, input logic [31:0] v,
                           input logic hs, input logic vs, input logic von,
                           input logic le, input logic fe, input logic [31:0] fc);
    int ht, vt, eh, ev, efc;
    bit ehs, evs;
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    eh  = n % ht;
    ev  = (n / ht) % vt;
    efc = (n / (ht * vt)) % 256;
    ehs = (eh >= ha + hf && eh < ha + hf + hsw) ? hpol : !hpol;
    evs = (ev >= va + vf && ev < va + vf + vsw) ? vpol : !vpol;
    chk({tag, ".h_count"}, h, eh);
    chk({tag, ".v_count"}, v, ev);
    chk({tag, ".hsync"}, {31'd0, hs}, {31'd0, ehs});
    chk({tag, ".vsync"}, {31'd0, vs}, {31'd0, evs});
    chk({tag, ".video_on"}, {31'd0, von}, (eh < ha && ev < va) ? 1 : 0);
    chk({tag, ".line_end"}, {31'd0, le}, (eh == ht - 1) ? 1 : 0);
    chk({tag, ".frame_end"}, {31'd0, fe}, (eh == ht - 1 && ev == vt - 1) ? 1 : 0);
    chk({tag, ".frame_count"}, fc, efc);
  endtask

  task automatic check_a();
    check_dut("a", n_a, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
              {16'd0, h_a}, {16'd0, v_a}, hs_a, vs_a, von_a, le_a, fe_a, {24'd0, fc_a});
  endtask

  task automatic check_b();
    check_dut("b", n_b, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1,
              {16'd0, h_b}, {16'd0, v_b}, hs_b, vs_b, von_b, le_b, fe_b, {24'd0, fc_b});
  endtask

  task automatic step(input logic ea, input logic eb);
    en_a = ea;
    en_b = eb;
    @(posedge clk);
    #1;
    if (!rst_a && en_a) n_a++;
    if (!rst_b && en_b) n_b++;
    if (fc_b == 8'd255) saw_fc255 = 1'b1;
    check_a();
    check_b();
  endtask

  initial begin
    // Reset held across a few edges with en asserted: everything stays at reset values.
    en_a = 1'b1;
    en_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_a();
    check_b();
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Free run: more than two full default lines.
    for (int i = 0; i < 1700; i++) step(1'b1, 1'b1);

    // Enable toggling every cycle: counts and strobes hold on idle cycles.
    for (int i = 0; i < 600; i++) step(1'(i % 2), 1'(i % 2));

    // Run A to column 300 of a later line, then reset asynchronously mid-line.
    for (int i = 0; i < 2000 && !(n_a % 800 == 300 && n_a >= 800); i++)
      step(1'b1, 1'($urandom_range(0, 1)));
    chk("a.reached_h300", n_a % 800, 300);
    rst_a = 1'b1;
    #1;
    n_a = 0;
    check_a();
    #2;
    rst_a = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);

    // Random stalls on both; B runs past its 256th frame so frame_count wraps.
    for (int i = 0; i < 60000 && n_b < 25088 + 40; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
    chk("b.enough_frames", (n_b >= 25088 + 40) ? 1 : 0, 1);
    chk("b.saw_frame_count_255", {31'd0, saw_fc255}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator, successor to the free-running horizontal counter. It combines horizontal and vertical counters with a pixel-enable stall, sync-polarity control, a blanking decode, line/frame strobes and a frame counter. It sits between the pixel clock source and the game renderer/sprite logic, which consume the counts and video_on.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
CNT_W, 16, width of h_count/v_count
FRM_W, 8, width of frame_count

Ports:
clk_25MHz  input  1  pixel clock
rst  input  1  asynchronous reset, active-high
en  input  1  pixel advance enable; low = hold all state
h_count  output  CNT_W  current column, 0..H_TOTAL-1
v_count  output  CNT_W  current line, 0..V_TOTAL-1
hsync  output  1  horizontal sync, polarity per HS_POL
vsync  output  1  vertical sync, polarity per VS_POL
video_on  output  1  high when h_count<H_ACTIVE and v_count<V_ACTIVE
line_end  output  1  high while h_count==H_TOTAL-1
frame_end  output  1  high while h_count==H_TOTAL-1 and v_count==V_TOTAL-1
frame_count  output  FRM_W  completed-frame counter, wraps

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525).
- Elaboration error if H_TOTAL or V_TOTAL exceeds 2^CNT_W, or if any porch/sync parameter is 0.
- Reset (async assert, sync release on clk_25MHz): h_count=0, v_count=0, frame_count=0, hsync=!HS_POL, vsync=!VS_POL, video_on=1, line_end=0, frame_end=0.
- All outputs are registers. hsync, vsync, video_on, line_end and frame_end are computed from next-state counts, so they always describe the h_count/v_count presented in the same cycle. No extra latency between counts and decodes.
- Per rising edge with en=1:
  - h_count increments. At H_TOTAL-1 it wraps to 0.
  - v_count increments only on the h wrap. At V_TOTAL-1 it wraps to 0 on the h wrap.
  - frame_count increments on the simultaneous h+v wrap, modulo 2^FRM_W.
- en=0: every register holds, including the strobes. A strobe that is high stays high until the count advances. en may toggle on any cycle.
- hsync active when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC (default 656..751).
- vsync active when V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC (default 490..491). vsync depends only on v_count.
- Reset mid-frame: immediate return to the reset values on the next sampling of state. No partial-line completion.
- Counts never exceed TOTAL-1. An unreachable count value (e.g. X-corruption) maps to the wrap branch and returns to 0.

Decomposition:
- Shared package vga_pkg holds the default 640x480@60 timing constants and the polarity encodings, so the renderer can reuse H_ACTIVE/V_ACTIVE.
- One natural sub-module: wrap_counter (parametrised MAX, with enable, async reset, and a registered terminal-count output), instantiated for the horizontal axis and the vertical axis.
- The sync and blank decode stays in the top module.

Test Plan:
1. Reset with defaults, en=1 for 800 cycles -> h_count steps 0..799 then 0; line_end high only at h=799; v_count goes 0->1 on the wrap; hsync low exactly for h=656..751.
2. Run a full frame of 420000 enabled cycles -> vsync low only for v=490..491; frame_end single-cycle at (799,524); frame_count 0->1; video_on count per frame = 307200.
3. en toggled 1/0 every cycle -> counts advance once per two clocks; frame_end stays high for 2 cycles at (799,524).
4. Assert rst at (h=300, v=200) -> counts=0, hsync=vsync=1, video_on=1 immediately; after release, counting restarts from 0.
5. Parameters HS_POL=1, VS_POL=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 -> H_TOTAL=14, V_TOTAL=7; hsync high for h=10..11; vsync high for v=5.
6. With the small parameters of scenario 5, run 256 frames (25088 cycles) -> frame_count wraps 255->0 on the last frame_end.
